// File: rtl/ram_bist_if.sv
// RAM pin bundle between the BIST sequencer (master) and the single-port RAM (slave).
interface ram_bist_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 16
);
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic              ram_rw;
   logic              ram_clr;
   logic [DATA_W-1:0] ram_dout;

   modport master (output ram_addr, ram_din, ram_rw, ram_clr, input ram_dout);
   modport slave  (input ram_addr, ram_din, ram_rw, ram_clr, output ram_dout);
endinterface

// File: rtl/ram_bist.sv
// BIST sequencer: clear, zero-check, then pattern / inverse-pattern march over the RAM,
// recording the first mismatching address and the data read there.
module ram_bist #(
   parameter int unsigned       ADDR_W = 10,
   parameter int unsigned       DATA_W = 16,
   parameter logic [DATA_W-1:0] SEED   = DATA_W'(16'hA5C3)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   ram_bist_if.master        bus,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data
);
   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_CHK0, S_WR, S_RD, S_WRI, S_RDI, S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
      return SEED ^ {a[DATA_W-ADDR_W-1:0], a};
   endfunction

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              drain_q, drain_d;
   logic              pend_q, pend_d;
   logic [DATA_W-1:0] exp_q, exp_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              busy_d, done_d, pass_d;
   logic [ADDR_W-1:0] fail_addr_d, ram_addr_d;
   logic [DATA_W-1:0] fail_data_d, ram_din_d;
   logic              ram_rw_d, ram_clr_d;
   logic              rd_state, desc, last, mismatch;

   // Compare the read issued last cycle against its registered expectation
   assign mismatch = pend_q && (bus.ram_dout != exp_q);
   assign rd_state = (state_q == S_CHK0) || (state_q == S_RD) || (state_q == S_RDI);
   assign desc     = (state_q == S_WRI) || (state_q == S_RDI);
   assign last     = desc ? (cnt_q == '0) : (cnt_q == ADDR_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         drain_q      <= 1'b0;
         pend_q       <= 1'b0;
         exp_q        <= '0;
         paddr_q      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         fail_addr    <= '0;
         fail_data    <= '0;
         bus.ram_addr <= '0;
         bus.ram_din  <= '0;
         bus.ram_rw   <= 1'b1;
         bus.ram_clr  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         drain_q      <= drain_d;
         pend_q       <= pend_d;
         exp_q        <= exp_d;
         paddr_q      <= paddr_d;
         busy         <= busy_d;
         done         <= done_d;
         pass         <= pass_d;
         fail_addr    <= fail_addr_d;
         fail_data    <= fail_data_d;
         bus.ram_addr <= ram_addr_d;
         bus.ram_din  <= ram_din_d;
         bus.ram_rw   <= ram_rw_d;
         bus.ram_clr  <= ram_clr_d;
      end
   end

   // Next state; RAM pins are derived from the next state so they line up with it
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      drain_d     = 1'b0;
      busy_d      = busy;
      done_d      = done;
      pass_d      = pass;
      fail_addr_d = fail_addr;
      fail_data_d = fail_data;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d     = S_CLR;
               cnt_d       = '0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               fail_addr_d = '0;
               fail_data_d = '0;
            end
         end
         S_CLR: begin
            state_d = S_CHK0;
            cnt_d   = '0;
         end
         S_CHK0, S_RD, S_RDI: begin
            if (mismatch) begin
               state_d     = S_DONE;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               pass_d      = 1'b0;
               fail_addr_d = paddr_q;
               fail_data_d = bus.ram_dout;
            end else if (drain_q) begin
               if (state_q == S_CHK0) begin
                  state_d = S_WR;
                  cnt_d   = '0;
               end else if (state_q == S_RD) begin
                  state_d = S_WRI;
                  cnt_d   = ADDR_MAX;
               end else begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
               end
            end else if (last) begin
               drain_d = 1'b1;
            end else begin
               cnt_d = desc ? cnt_q - ADDR_W'(1) : cnt_q + ADDR_W'(1);
            end
         end
         S_WR, S_WRI: begin
            if (last) begin
               state_d = (state_q == S_WR) ? S_RD : S_RDI;
               cnt_d   = (state_q == S_WR) ? '0 : ADDR_MAX;
            end else begin
               cnt_d = desc ? cnt_q - ADDR_W'(1) : cnt_q + ADDR_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      ram_addr_d = cnt_d;
      ram_rw_d   = !((state_d == S_WR) || (state_d == S_WRI));
      ram_clr_d  = (state_d == S_CLR);
      ram_din_d  = (state_d == S_WR)  ? pat(cnt_d)  :
                   (state_d == S_WRI) ? ~pat(cnt_d) : '0;

      pend_d  = rd_state && !drain_q && !mismatch;
      paddr_d = cnt_q;
      case (state_q)
         S_RD:    exp_d = pat(cnt_q);
         S_RDI:   exp_d = ~pat(cnt_q);
         default: exp_d = '0;
      endcase
   end
endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: behavioural 1024x16 RAM with injectable faults, checked against
// a phase-level march model of the expected test outcome and run length.
module tb_ram_bist;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 16;
   localparam int          N  = 1024;
   localparam logic [DW-1:0] SEED = 16'hA5C3;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          busy, done, pass;
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_data;

   int checks = 0;
   int errors = 0;

   // Fault configuration shared by the RAM model and the reference model
   logic [AW-1:0] st_addr;
   logic [DW-1:0] sa1, sa0;
   logic [AW-1:0] dr_addr;
   logic [1:0]    dr_mask;

   ram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ram_bist #(.ADDR_W(AW), .DATA_W(DW), .SEED(SEED)) dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus),
      .busy(busy), .done(done), .pass(pass),
      .fail_addr(fail_addr), .fail_data(fail_data)
   );

   always #5 clk = ~clk;

   // Cycle-level RAM: sync clear-all, registered read, stuck bits and dropped writes
   logic [DW-1:0] ram_mem [N];
   logic [1:0]    ram_wc;
   logic          drop_c;
   assign drop_c = (bus.ram_addr == dr_addr) &&
                   ((ram_wc == 2'd0 && dr_mask[0]) || (ram_wc == 2'd1 && dr_mask[1]));

   always @(posedge clk) begin
      if (bus.ram_clr) begin
         for (int i = 0; i < N; i++) ram_mem[i] <= '0;
         ram_wc       <= 2'd0;
         bus.ram_dout <= '0;
      end else if (!bus.ram_rw) begin
         if (bus.ram_addr == dr_addr && ram_wc != 2'd3) ram_wc <= ram_wc + 2'd1;
         if (!drop_c) ram_mem[bus.ram_addr] <= bus.ram_din;
      end else begin
         bus.ram_dout <= (bus.ram_addr == st_addr) ?
                         ((ram_mem[bus.ram_addr] | sa1) & ~sa0) : ram_mem[bus.ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: whole-run outcome from the march rules over a plain array
   logic [DW-1:0] mem_m [N];
   int            wc_m;

   function automatic logic [DW-1:0] p_of(input int a);
      logic [AW-1:0] aa;
      logic [DW-1:0] ext;
      aa  = AW'(a);
      ext = {aa[DW-AW-1:0], aa};
      return SEED ^ ext;
   endfunction

   function automatic logic [DW-1:0] m_read(input int a);
      if (AW'(a) == st_addr) return (mem_m[a] | sa1) & ~sa0;
      return mem_m[a];
   endfunction

   task automatic m_write(input int a, input logic [DW-1:0] d);
      bit drop;
      drop = 1'b0;
      if (AW'(a) == dr_addr) begin
         drop = (wc_m < 2) && dr_mask[wc_m];
         wc_m++;
      end
      if (!drop) mem_m[a] = d;
   endtask

   task automatic model_run(output bit ok, output logic [AW-1:0] fa,
                            output logic [DW-1:0] fd, output int cyc);
      logic [DW-1:0] e, v;
      int a;
      ok = 1'b1; fa = '0; fd = '0;
      for (int i = 0; i < N; i++) mem_m[i] = '0;
      wc_m = 0;
      cyc  = 1;
      // phases: 0 check zero, 1 write P, 2 read P, 3 write ~P (down), 4 read ~P (down)
      for (int ph = 0; ph < 5; ph++) begin
         for (int i = 0; i < N; i++) begin
            a = (ph >= 3) ? N - 1 - i : i;
            cyc++;
            e = (ph == 0) ? '0 : (ph <= 2) ? p_of(a) : ~p_of(a);
            if (ph == 1 || ph == 3) begin
               m_write(a, e);
            end else begin
               v = m_read(a);
               if (v != e) begin
                  ok = 1'b0; fa = AW'(a); fd = v; cyc = cyc + 1;
                  return;
               end
            end
         end
         if (ph == 0 || ph == 2 || ph == 4) cyc++;
      end
   endtask

   task automatic clear_faults();
      st_addr = '0; sa1 = '0; sa0 = '0; dr_addr = '0; dr_mask = 2'b00;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_pass"}, 32'(pass), 32'd0);
      chk({tag, "_faddr"}, 32'(fail_addr), 32'd0);
      chk({tag, "_fdata"}, 32'(fail_data), 32'd0);
      chk({tag, "_raddr"}, 32'(bus.ram_addr), 32'd0);
      chk({tag, "_rdin"}, 32'(bus.ram_din), 32'd0);
      chk({tag, "_rw"}, 32'(bus.ram_rw), 32'd1);
      chk({tag, "_clr"}, 32'(bus.ram_clr), 32'd0);
   endtask

   // One full run: start pulse, count busy cycles, compare outcome with the model
   task automatic run_test(input string tag, input int restart_at);
      bit            ok;
      logic [AW-1:0] fa;
      logic [DW-1:0] fd;
      int            cyc, n;
      model_run(ok, fa, fd, cyc);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk({tag, "_done_clr"}, 32'(done), 32'd0);
      chk({tag, "_faddr_clr"}, 32'(fail_addr), 32'd0);
      chk({tag, "_clr_pin"}, 32'(bus.ram_clr), 32'd1);
      n = 0;
      while (busy && n < 6000) begin
         n++;
         start = (restart_at > 0) && (n == restart_at || n == restart_at + 2000);
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, "_cycles"}, 32'(n), 32'(cyc));
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_pass"}, 32'(pass), 32'(ok));
      chk({tag, "_faddr"}, 32'(fail_addr), 32'(fa));
      chk({tag, "_fdata"}, 32'(fail_data), 32'(fd));
      repeat (3) @(negedge clk);
      chk({tag, "_hold"}, 32'(done), 32'd1);
      chk({tag, "_rw_idle"}, 32'(bus.ram_rw), 32'd1);
   endtask

   initial begin
      int kind;
      reset = 1'b0;
      start = 1'b0;
      clear_faults();
      repeat (3) @(negedge clk);
      reset_checks("rst");
      reset = 1'b1;
      @(negedge clk);

      run_test("healthy", -1);
      chk("healthy_len", 32'(fail_addr == '0 && pass), 32'd1);

      sa1 = 16'h0008; st_addr = 10'h155;
      run_test("stuck155", -1);
      chk("stuck155_addr", 32'(fail_addr), 32'h155);
      chk("stuck155_data", 32'(fail_data), 32'h0008);
      clear_faults();

      dr_addr = 10'h2AA; dr_mask = 2'b11;
      run_test("drop2aa", -1);
      chk("drop2aa_addr", 32'(fail_addr), 32'h2AA);
      chk("drop2aa_data", 32'(fail_data), 32'h0000);
      clear_faults();

      // Abort a run in the middle of the pattern write phase
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (1600) @(negedge clk);
      chk("abort_in_wr", 32'(bus.ram_rw), 32'd0);
      reset = 1'b0;
      #1;
      reset_checks("abort");
      @(negedge clk) reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort_idle", 32'(busy), 32'd0);
      run_test("after_abort", -1);

      run_test("restart_ignored", 1000);
      chk("restart_pass", 32'(pass), 32'd1);

      dr_addr = 10'h000; dr_mask = 2'b10;
      run_test("rdi0", -1);
      chk("rdi0_data", 32'(fail_data), 32'hA5C3);
      clear_faults();

      for (int r = 0; r < 4; r++) begin
         clear_faults();
         kind = int'($urandom_range(0, 2));
         if (kind == 0) begin
            st_addr = AW'($urandom_range(0, N - 1));
            sa1 = DW'(1) << $urandom_range(0, DW - 1);
         end else if (kind == 1) begin
            st_addr = AW'($urandom_range(0, N - 1));
            sa0 = DW'(1) << $urandom_range(0, DW - 1);
         end else begin
            dr_addr = AW'($urandom_range(0, N - 1));
            dr_mask = 2'($urandom_range(1, 3));
         end
         run_test($sformatf("rnd%0d", r), -1);
      end
      clear_faults();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
